// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } wait_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Tracks outstanding data-memory accesses, freezes the pipeline while they
// are pending and latches a sticky error when an access exceeds TIMEOUT cycles.
module hazard_mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic dmem_req_M,
    input  logic dmem_ready,
    output logic freeze,
    output logic mem_error
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    wait_state_t   state;
    wait_state_t   next_state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] next_cnt;
    logic          mem_stall;

    assign mem_stall = dmem_req_M & ~dmem_ready;

    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        freeze     = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    freeze     = 1'b1;
                    next_state = WAIT;
                    next_cnt   = CW'(1);
                end
            end
            WAIT: begin
                if (mem_stall) begin
                    freeze   = 1'b1;
                    next_cnt = wait_cnt + CW'(1);
                    if (next_cnt == TIMEOUT_CNT) begin
                        next_state = ERROR;
                    end
                end else begin
                    next_state = RUN;
                    next_cnt   = '0;
                end
            end
            ERROR: begin
                // Only reset can recover a timed-out access.
                freeze = 1'b1;
            end
            default: begin
                next_state = RUN;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state     <= next_state;
            wait_cnt  <= next_cnt;
            mem_error <= mem_error | (next_state == ERROR);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use detection, branch flush, memory freeze
// with timeout, and a saturating stall-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       RD_E,
    input  logic             RegWriteE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    logic freeze;
    logic lw_stall;

    hazard_mem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_fsm (
        .clk        (clk),
        .rst        (rst),
        .dmem_req_M (dmem_req_M),
        .dmem_ready (dmem_ready),
        .freeze     (freeze),
        .mem_error  (mem_error)
    );

    assign lw_stall = ResultSrcE0 & RegWriteE & (RD_E != REG_ZERO) &
                      ((RD_E == Rs1_D) | (RD_E == Rs2_D));

    // Freeze outranks branch, which outranks load-use; everything idles in reset.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst) begin
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (StallF && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (TIMEOUT=4, CNT_W=3).
module tb_hazard_unit;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, RD_E;
    logic       RegWriteE, ResultSrcE0, PCSrcE, dmem_req_M, dmem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic       mem_error;
    logic [2:0] stall_cycles;
    logic [6:0] ctl;

    int checks   = 0;
    int failures = 0;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] NONE = 7'b0000_000;
    localparam logic [6:0] FRZ  = 7'b1111_001;
    localparam logic [6:0] BR   = 7'b0000_110;
    localparam logic [6:0] LW   = 7'b1100_010;

    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    hazard_unit #(
        .TIMEOUT (4),
        .CNT_W   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Rs1_D        (Rs1_D),
        .Rs2_D        (Rs2_D),
        .RD_E         (RD_E),
        .RegWriteE    (RegWriteE),
        .ResultSrcE0  (ResultSrcE0),
        .PCSrcE       (PCSrcE),
        .dmem_req_M   (dmem_req_M),
        .dmem_ready   (dmem_ready),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .mem_error    (mem_error),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        Rs1_D = 5'd0; Rs2_D = 5'd0; RD_E = 5'd0;
        RegWriteE = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
        dmem_req_M = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic drive_load_use;
        ResultSrcE0 = 1'b1; RegWriteE = 1'b1; RD_E = 5'd5; Rs1_D = 5'd5; Rs2_D = 5'd7;
    endtask

    task automatic apply_reset;
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        drive_load_use();
        dmem_req_M = 1'b1;
        rst = 1'b1;
        #2;
        checks++;
        if (ctl !== NONE) begin failures++; $display("FAIL reset_ctl: got %b expected %b", ctl, NONE); end
        checks++;
        if (mem_error !== 1'b0) begin failures++; $display("FAIL reset_mem_error: got %b expected 0", mem_error); end
        checks++;
        if (stall_cycles !== 3'd0) begin failures++; $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles); end
        tick();
        rst = 1'b0;
        drive_idle();
        #1;
        checks++;
        if (ctl !== NONE) begin failures++; $display("FAIL reset_release_ctl: got %b expected %b", ctl, NONE); end
    endtask

    task automatic test_load_use;
        apply_reset();
        drive_load_use();
        #1;
        checks++;
        if (ctl !== LW) begin failures++; $display("FAIL lu_rs1_ctl: got %b expected %b", ctl, LW); end
        checks++;
        if (stall_cycles !== 3'd0) begin failures++; $display("FAIL lu_cnt_before: got %0d expected 0", stall_cycles); end
        tick();
        checks++;
        if (stall_cycles !== 3'd1) begin failures++; $display("FAIL lu_cnt_after: got %0d expected 1", stall_cycles); end
        drive_idle();
        #1;
        checks++;
        if (ctl !== NONE) begin failures++; $display("FAIL lu_advanced_ctl: got %b expected %b", ctl, NONE); end
        drive_load_use();
        RD_E = 5'd7;
        #1;
        checks++;
        if (ctl !== LW) begin failures++; $display("FAIL lu_rs2_ctl: got %b expected %b", ctl, LW); end
        RegWriteE = 1'b0;
        #1;
        checks++;
        if (ctl !== NONE) begin failures++; $display("FAIL lu_nowrite_ctl: got %b expected %b", ctl, NONE); end
        drive_load_use();
        RD_E = 5'd0; Rs1_D = 5'd0; Rs2_D = 5'd0;
        #1;
        checks++;
        if (ctl !== NONE) begin failures++; $display("FAIL lu_x0_ctl: got %b expected %b", ctl, NONE); end
        tick();
        checks++;
        if (stall_cycles !== 3'd1) begin failures++; $display("FAIL lu_x0_cnt: got %0d expected 1", stall_cycles); end
    endtask

    task automatic test_branch_over_load_use;
        apply_reset();
        drive_load_use();
        PCSrcE = 1'b1;
        #1;
        checks++;
        if (ctl !== BR) begin failures++; $display("FAIL br_lu_ctl: got %b expected %b", ctl, BR); end
        tick();
        checks++;
        if (stall_cycles !== 3'd0) begin failures++; $display("FAIL br_lu_cnt: got %0d expected 0", stall_cycles); end
        drive_idle();
    endtask

    task automatic test_mem_wait;
        apply_reset();
        dmem_req_M = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== FRZ) begin failures++; $display("FAIL mw_freeze_%0d: got %b expected %b", i, ctl, FRZ); end
            tick();
        end
        checks++;
        if (stall_cycles !== 3'd3) begin failures++; $display("FAIL mw_cnt: got %0d expected 3", stall_cycles); end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== NONE) begin failures++; $display("FAIL mw_ready_ctl: got %b expected %b", ctl, NONE); end
        tick();
        checks++;
        if (stall_cycles !== 3'd3) begin failures++; $display("FAIL mw_ready_cnt: got %0d expected 3", stall_cycles); end
        // A fresh 3-cycle wait must not time out if the counter restarted in RUN.
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (mem_error !== 1'b0) begin failures++; $display("FAIL mw_rerun_err: got %b expected 0", mem_error); end
        checks++;
        if (stall_cycles !== 3'd6) begin failures++; $display("FAIL mw_rerun_cnt: got %0d expected 6", stall_cycles); end
        dmem_ready = 1'b1;
        tick();
        drive_idle();
    endtask

    task automatic test_timeout;
        apply_reset();
        dmem_req_M = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (mem_error !== (i == 4)) begin
                failures++; $display("FAIL to_err_edge%0d: got %b expected %b", i, mem_error, (i == 4));
            end
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== FRZ) begin failures++; $display("FAIL to_sticky_ctl: got %b expected %b", ctl, FRZ); end
        tick();
        checks++;
        if (mem_error !== 1'b1 || ctl !== FRZ) begin
            failures++; $display("FAIL to_sticky_hold: got err=%b ctl=%b expected err=1 ctl=%b", mem_error, ctl, FRZ);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_error !== 1'b0 || ctl !== NONE || stall_cycles !== 3'd0) begin
            failures++; $display("FAIL to_reset: got err=%b ctl=%b cnt=%0d expected 0/%b/0", mem_error, ctl, stall_cycles, NONE);
        end
        tick();
        rst = 1'b0;
        drive_idle();
        #1;
        checks++;
        if (ctl !== NONE) begin failures++; $display("FAIL to_after_reset_ctl: got %b expected %b", ctl, NONE); end
    endtask

    task automatic test_reset_mid_wait;
        apply_reset();
        dmem_req_M = 1'b1;
        dmem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== NONE) begin failures++; $display("FAIL rmw_ctl: got %b expected %b", ctl, NONE); end
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== FRZ) begin failures++; $display("FAIL rmw_refreeze: got %b expected %b", ctl, FRZ); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (mem_error !== (i == 4)) begin
                failures++; $display("FAIL rmw_err_edge%0d: got %b expected %b", i, mem_error, (i == 4));
            end
        end
    endtask

    task automatic test_freeze_branch;
        apply_reset();
        dmem_req_M = 1'b1;
        dmem_ready = 1'b0;
        PCSrcE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ctl !== FRZ) begin failures++; $display("FAIL fb_freeze_%0d: got %b expected %b", i, ctl, FRZ); end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== BR) begin failures++; $display("FAIL fb_ready_ctl: got %b expected %b", ctl, BR); end
        tick();
        drive_idle();
    endtask

    task automatic test_load_use_during_freeze;
        apply_reset();
        drive_load_use();
        dmem_req_M = 1'b1;
        dmem_ready = 1'b0;
        #1;
        checks++;
        if (ctl !== FRZ) begin failures++; $display("FAIL luf_freeze: got %b expected %b", ctl, FRZ); end
        tick();
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== LW) begin failures++; $display("FAIL luf_after_ctl: got %b expected %b", ctl, LW); end
        tick();
        checks++;
        if (stall_cycles !== 3'd2) begin failures++; $display("FAIL luf_cnt: got %0d expected 2", stall_cycles); end
        drive_idle();
    endtask

    task automatic test_saturation;
        logic [2:0] exp_cnt;
        apply_reset();
        dmem_req_M = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_cnt = (i > 7) ? 3'd7 : 3'(i);
            checks++;
            if (stall_cycles !== exp_cnt) begin
                failures++; $display("FAIL sat_edge%0d: got %0d expected %0d", i, stall_cycles, exp_cnt);
            end
        end
        drive_idle();
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        #1;
        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_freeze_branch();
        test_load_use_during_freeze();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
